// File: rtl/seq_pkg.sv
// Shared definitions for the SEQ Y86-64 stage sequencer.
// Holds icodes, status codes, register IDs, the sequencer state encoding and icode helpers.
// No logic of its own; consumed by seq_reg_select and seq_stage_ctrl.
package seq_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPDATE,
        ST_HALT
    } state_t;

    // Instructions that touch data memory in the MEMORY stage.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
               (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
    endfunction

    // Subset of memory instructions that store rather than load.
    function automatic logic is_mem_wr_icode(input logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
    endfunction

endpackage

// File: rtl/seq_reg_select.sv
// Register-file source/destination ID selection from icode, rA and rB.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module seq_reg_select
    import seq_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ra,
    input  logic [3:0] rb,
    output logic [3:0] src_a,
    output logic [3:0] src_b,
    output logic [3:0] dst_e,
    output logic [3:0] dst_m
);

    // Per-instruction port usage; anything unlisted reads and writes nothing.
    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (icode)
            I_RRMOVQ: begin src_a = ra;      dst_e = rb;                        end
            I_IRMOVQ: begin dst_e = rb;                                         end
            I_RMMOVQ: begin src_a = ra;      src_b = rb;                        end
            I_MRMOVQ: begin src_b = rb;      dst_m = ra;                        end
            I_OPQ:    begin src_a = ra;      src_b = rb;      dst_e = rb;       end
            I_CALL:   begin src_b = REG_RSP; dst_e = REG_RSP;                   end
            I_RET:    begin src_a = REG_RSP; src_b = REG_RSP; dst_e = REG_RSP;  end
            I_PUSHQ:  begin src_a = ra;      src_b = REG_RSP; dst_e = REG_RSP;  end
            I_POPQ:   begin src_a = REG_RSP; src_b = REG_RSP; dst_e = REG_RSP;
                            dst_m = ra;                                         end
            I_HALT, I_NOP, I_JXX: begin end
            default:  begin end
        endcase
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle SEQ Y86-64 sequencer: one-hot stage strobes, regfile IDs, dmem handshake, status.
// 6 cycles per non-memory instruction, 5+N with N MEMORY cycles; outputs decoded from flops only.
// MEMORY holds mem_req until mem_ack or MEM_TIMEOUT cycles; optional counters via SEQ_PERF_CNT_EN.
module seq_stage_ctrl
    import seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        cnd,
    input  logic        mem_ack,
    input  logic        dmem_error,
    output logic        f_en,
    output logic        d_en,
    output logic        e_en,
    output logic        m_en,
    output logic        w_en,
    output logic        pc_en,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic        wE,
    output logic        wM,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [2:0]  stat,
    output logic        busy,
    output logic        halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    // Count value seen during the last permitted request cycle.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic        cnd_q, cnd_d;
    logic [2:0]  stat_q, stat_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mem_op;

    assign mem_op = is_mem_icode(icode_q);

    // Register IDs derive from the captured instruction so they hold steady D..P.
    seq_reg_select u_reg_select (
        .icode (icode_q),
        .ra    (ra_q),
        .rb    (rb_q),
        .src_a (srcA),
        .src_b (srcB),
        .dst_e (dstE),
        .dst_m (dstM)
    );

    // Next-state, instruction capture, status and MEMORY timeout bookkeeping.
    always_comb begin
        state_d = state_q;
        icode_d = icode_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        cnd_d   = cnd_q;
        stat_d  = stat_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_error) begin
                    stat_d  = STAT_ADR;
                    state_d = ST_HALT;
                end else if (!instr_valid) begin
                    stat_d  = STAT_INS;
                    state_d = ST_HALT;
                end else if (icode == I_HALT) begin
                    stat_d  = STAT_HLT;
                    state_d = ST_HALT;
                end else begin
                    icode_d = icode;
                    ra_d    = rA;
                    rb_d    = rB;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                cnd_d   = cnd;
                tmo_d   = '0;
                state_d = ST_MEMORY;
            end
            ST_MEMORY: begin
                if (!mem_op) begin
                    state_d = ST_WRITEBACK;
                end else if (mem_ack) begin
                    // An ack always beats a timeout landing in the same cycle.
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    stat_d  = STAT_ADR;
                    state_d = ST_HALT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_WRITEBACK: state_d = ST_PCUPDATE;
            ST_PCUPDATE:  state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State and captured-instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            icode_q <= I_HALT;
            ra_q    <= REG_NONE;
            rb_q    <= REG_NONE;
            cnd_q   <= 1'b0;
            stat_q  <= STAT_AOK;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            icode_q <= icode_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            cnd_q   <= cnd_d;
            stat_q  <= stat_d;
            tmo_q   <= tmo_d;
        end
    end

    assign f_en    = (state_q == ST_FETCH);
    assign d_en    = (state_q == ST_DECODE);
    assign e_en    = (state_q == ST_EXECUTE);
    assign m_en    = (state_q == ST_MEMORY);
    assign w_en    = (state_q == ST_WRITEBACK);
    assign pc_en   = (state_q == ST_PCUPDATE);
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted  = (state_q == ST_HALT);
    assign stat    = stat_q;
    assign mem_req = m_en && mem_op;
    assign mem_wr  = mem_req && is_mem_wr_icode(icode_q);
    // A conditional move whose condition failed writes nothing.
    assign wE      = w_en && (dstE != REG_NONE) && !((icode_q == I_RRMOVQ) && !cnd_q);
    assign wM      = w_en && (dstM != REG_NONE);

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ret_cnt_q, ret_cnt_d;

    // Saturating busy-cycle and retired-instruction counters.
    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        ret_cnt_d = ret_cnt_q;
        if (busy && (cyc_cnt_q != '1))  cyc_cnt_d = cyc_cnt_q + 32'd1;
        if (pc_en && (ret_cnt_q != '1)) ret_cnt_d = ret_cnt_q + 32'd1;
    end

    // Counter registers clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl with randomized don't-care inputs.
// Expected per-cycle behaviour comes from a stage-list model built from the instruction rules.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seq_stage_ctrl;

    localparam int TMO = 15;
    localparam int SF = 0, SD = 1, SE = 2, SM = 3, SW = 4, SP = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] icode = 4'h0, rA = 4'h0, rB = 4'h0;
    logic       instr_valid = 1'b0, imem_error = 1'b0, cnd = 1'b0;
    logic       mem_ack = 1'b0, dmem_error = 1'b0;
    logic       f_en, d_en, e_en, m_en, w_en, pc_en;
    logic [3:0] srcA, srcB, dstE, dstM;
    logic       wE, wM, mem_req, mem_wr, busy, halted;
    logic [2:0] stat;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_stage_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .rA(rA), .rB(rB),
        .instr_valid(instr_valid), .imem_error(imem_error), .cnd(cnd),
        .mem_ack(mem_ack), .dmem_error(dmem_error),
        .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en), .pc_en(pc_en),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM), .wE(wE), .wM(wM),
        .mem_req(mem_req), .mem_wr(mem_wr), .stat(stat), .busy(busy), .halted(halted)
`ifdef SEQ_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    // Register-ID rules as icode membership masks: which = 0 srcA, 1 srcB, 2 dstE, 3 dstM.
    function automatic logic [3:0] exp_reg(input int which, input logic [3:0] ic,
                                           input logic [3:0] ra, input logic [3:0] rb);
        logic [15:0] ra_m, rb_m, rsp_m;
        ra_m = 16'h0; rb_m = 16'h0; rsp_m = 16'h0;
        case (which)
            0: begin ra_m = 16'h0454; rsp_m = 16'h0A00; end
            1: begin rb_m = 16'h0070; rsp_m = 16'h0F00; end
            2: begin rb_m = 16'h004C; rsp_m = 16'h0F00; end
            default: ra_m = 16'h0820;
        endcase
        if (ra_m[ic]) return ra;
        if (rb_m[ic]) return rb;
        if (rsp_m[ic]) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [14:0] obs_vec();
        return {f_en, d_en, e_en, m_en, w_en, pc_en, wE, wM, mem_req, mem_wr, busy, halted, stat};
    endfunction

    task automatic randomize_inputs();
        start       = 1'($urandom);
        icode       = 4'($urandom);
        rA          = 4'($urandom);
        rB          = 4'($urandom);
        instr_valid = 1'($urandom);
        imem_error  = 1'($urandom);
        cnd         = 1'($urandom);
        mem_ack     = 1'($urandom);
        dmem_error  = 1'($urandom);
    endtask

    // Runs one instruction starting at a FETCH cycle. ack_at: request cycle of ack (0 = never).
    // rst_m: MEMORY cycle in which to assert reset (0 = none). Ends in FETCH-next or HALT.
    task automatic run_instr(input logic [3:0] ic, input logic [3:0] ira, input logic [3:0] irb,
                             input bit iv, input bit im_err, input bit c,
                             input int ack_at, input bit derr, input int rst_m);
        int stg[$];
        int m_idx;
        bit mem_i, wr_i, to_halt;
        logic [2:0]  halt_stat;
        logic [15:0] mem_mask, wr_mask;
        logic [5:0]  top_bit, strb;
        logic [14:0] exp_v, got_v;
        logic [15:0] exp_r, got_r;
        mem_mask = 16'h0F30;
        wr_mask  = 16'h0510;
        top_bit  = 6'b100000;
        mem_i = mem_mask[ic];
        wr_i  = wr_mask[ic];
        to_halt = 1'b0;
        halt_stat = 3'd1;
        m_idx = 0;
        stg.push_back(SF);
        if (im_err) begin
            to_halt = 1'b1; halt_stat = 3'd3;
        end else if (!iv) begin
            to_halt = 1'b1; halt_stat = 3'd4;
        end else if (ic == 4'h0) begin
            to_halt = 1'b1; halt_stat = 3'd2;
        end else begin
            int n_m;
            bit acked;
            acked = (ack_at >= 1) && (ack_at <= TMO);
            stg.push_back(SD);
            stg.push_back(SE);
            n_m = !mem_i ? 1 : (acked ? ack_at : TMO);
            for (int i = 0; i < n_m; i++) stg.push_back(SM);
            if (mem_i && (!acked || derr)) begin
                to_halt = 1'b1; halt_stat = 3'd3;
            end else begin
                stg.push_back(SW);
                stg.push_back(SP);
            end
        end
        exp_r = {exp_reg(0, ic, ira, irb), exp_reg(1, ic, ira, irb),
                 exp_reg(2, ic, ira, irb), exp_reg(3, ic, ira, irb)};
        for (int k = 0; k < stg.size(); k++) begin
            @(negedge clk);
            strb = top_bit >> stg[k];
            exp_v = {strb,
                     1'(stg[k] == SW && exp_r[7:4] != 4'hF && !(ic == 4'h2 && !c)),
                     1'(stg[k] == SW && exp_r[3:0] != 4'hF),
                     1'(stg[k] == SM && mem_i),
                     1'(stg[k] == SM && mem_i && wr_i),
                     1'b1, 1'b0, 3'd1};
            got_v = obs_vec();
            n_checks++;
            if (got_v !== exp_v)
                $display("FAIL stage_outputs ic=%h step=%0d got=%b exp=%b", ic, k, got_v, exp_v);
            else
                n_pass++;
            if (stg[k] != SF) begin
                got_r = {srcA, srcB, dstE, dstM};
                n_checks++;
                if (got_r !== exp_r)
                    $display("FAIL reg_ids ic=%h step=%0d got=%h exp=%h", ic, k, got_r, exp_r);
                else
                    n_pass++;
            end
            randomize_inputs();
            if (stg[k] == SF) begin
                icode = ic; rA = ira; rB = irb; instr_valid = iv; imem_error = im_err;
            end
            if (stg[k] == SE) cnd = c;
            if (stg[k] == SM) begin
                m_idx++;
                mem_ack = (m_idx == ack_at);
                if (mem_ack) dmem_error = derr;
                if (m_idx == rst_m) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    got_v = obs_vec();
                    got_r = {srcA, srcB, dstE, dstM};
                    n_checks++;
                    if ({got_v, got_r} !== {15'b000000_0000_00_001, 16'hFFFF})
                        $display("FAIL reset_mid_memory got=%b/%h exp=%b/%h",
                                 got_v, got_r, 15'b000000_0000_00_001, 16'hFFFF);
                    else
                        n_pass++;
                    rst_n = 1'b1;
                    start = 1'b0;
                    return;
                end
            end
        end
        if (to_halt) begin
            @(negedge clk);
            exp_v = {6'b0, 4'b0, 1'b0, 1'b1, halt_stat};
            got_v = obs_vec();
            n_checks++;
            if (got_v !== exp_v)
                $display("FAIL halt_entry ic=%h got=%b exp=%b", ic, got_v, exp_v);
            else
                n_pass++;
            randomize_inputs();
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== 15'b000000_0000_00_001)
            $display("FAIL idle_before_start got=%b exp=%b", obs_vec(), 15'b000000_0000_00_001);
        else
            n_pass++;
        start = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({obs_vec(), srcA, srcB, dstE, dstM} !== {15'b000000_0000_00_001, 16'hFFFF})
            $display("FAIL reset_values got=%b/%h", obs_vec(), {srcA, srcB, dstE, dstM});
        else
            n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic check_sticky(input logic [2:0] st);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== {6'b0, 4'b0, 1'b0, 1'b1, st})
                $display("FAIL halt_sticky cyc=%0d got=%b exp=%b", i, obs_vec(), {6'b0, 4'b0, 1'b0, 1'b1, st});
            else
                n_pass++;
            start = (i % 2 == 0);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({obs_vec(), srcA, srcB, dstE, dstM} !== {15'b000000_0000_00_001, 16'hFFFF})
                $display("FAIL reset_hold cyc=%0d got=%b/%h", i, obs_vec(), {srcA, srcB, dstE, dstM});
            else
                n_pass++;
            randomize_inputs();
        end
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== 15'b000000_0000_00_001)
            $display("FAIL idle_no_start got=%b exp=%b", obs_vec(), 15'b000000_0000_00_001);
        else
            n_pass++;
    endtask

    task automatic test_irmovq();
        run_instr(4'h3, 4'($urandom), 4'h2, 1, 0, 1'($urandom), 0, 0, 0);
    endtask

    task automatic test_mrmovq();
        run_instr(4'h5, 4'h1, 4'h3, 1, 0, 1'($urandom), 3, 0, 0);
    endtask

    task automatic test_cmov();
        run_instr(4'h2, 4'h5, 4'h6, 1, 0, 0, 0, 0, 0);
        run_instr(4'h2, 4'h5, 4'h6, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic test_ack_at_timeout();
        run_instr(4'h4, 4'($urandom), 4'($urandom), 1, 0, 0, TMO, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            run_instr(4'($urandom_range(1, 11)), 4'($urandom), 4'($urandom), 1, 0,
                      1'($urandom), $urandom_range(1, 5), 0, 0);
    endtask

    task automatic test_dmem_error();
        run_instr(4'h5, 4'($urandom), 4'($urandom), 1, 0, 0, 2, 1, 0);
        check_sticky(3'd3);
        do_reset();
    endtask

    task automatic test_pushq_timeout();
        do_start();
        run_instr(4'hA, 4'h7, 4'($urandom), 1, 0, 0, 0, 0, 0);
        check_sticky(3'd3);
        do_reset();
    endtask

    task automatic test_invalid();
        do_start();
        run_instr(4'($urandom), 4'($urandom), 4'($urandom), 0, 0, 0, 0, 0, 0);
        check_sticky(3'd4);
        do_reset();
    endtask

    task automatic test_imem_error();
        do_start();
        run_instr(4'($urandom_range(1, 11)), 4'($urandom), 4'($urandom), 1, 1, 0, 0, 0, 0);
        check_sticky(3'd3);
        do_reset();
    endtask

    task automatic test_halt_instr();
        do_start();
        run_instr(4'h0, 4'($urandom), 4'($urandom), 1, 0, 0, 0, 0, 0);
        check_sticky(3'd2);
        do_reset();
    endtask

    task automatic test_reset_mid_memory();
        do_start();
        run_instr(4'hB, 4'($urandom), 4'($urandom), 1, 0, 1'($urandom), 5, 0, 2);
        do_start();
        run_instr(4'h1, 4'($urandom), 4'($urandom), 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        do_start();
        test_irmovq();
        test_mrmovq();
        test_cmov();
        test_ack_at_timeout();
        test_random();
        test_dmem_error();
        test_pushq_timeout();
        test_invalid();
        test_imem_error();
        test_halt_instr();
        test_reset_mid_memory();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Multi-cycle sequencer for the SEQ Y86-64 core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPDATE using one-hot stage strobes. It derives register-file source and destination IDs from icode/rA/rB, handshakes with data memory, and tracks processor status. It sits above the fetch, decode, execute, memory and writeback blocks and owns all of their enables.

## Interface
- MEM_TIMEOUT, 15: cycles MEMORY waits for mem_ack before flagging ADR (1..255).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  leave IDLE and begin fetching; ignored in any other state.
- icode  in  4  instruction code from fetch, valid at end of FETCH.
- rA, rB  in  4  register specifiers from fetch, valid at end of FETCH.
- instr_valid  in  1  fetch reports a legal icode/ifun.
- imem_error  in  1  fetch address out of range.
- cnd  in  1  condition result from execute, valid at end of EXECUTE.
- mem_ack  in  1  data memory completes the access.
- dmem_error  in  1  data-memory address error, qualified by mem_ack.
- f_en, d_en, e_en, m_en, w_en, pc_en  out  1 each  one-hot stage strobes.
- srcA, srcB, dstE, dstM  out  4 each  register IDs; 4'hF = none.
- wE, wM  out  1 each  register-file write strobes for dstE/valE and dstM/valM.
- mem_req, mem_wr  out  1 each  data-memory request and write qualifier.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  out  1  state is neither IDLE nor HALT.
- halted  out  1  state is HALT.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, HALT. Each strobe is high exactly while its state is current.
- IDLE→FETCH when start is high.
- At the end of FETCH:
  - imem_error → stat=ADR, go to HALT.
  - Otherwise, !instr_valid → stat=INS, go to HALT.
  - Otherwise, icode==0 (halt) → stat=HLT, go to HALT.
  - Otherwise capture icode, rA and rB, then go to DECODE.
- srcA = rA for icodes 2, 4, 6, A; 4 (rsp) for icodes 9, B; else F.
- srcB = rB for icodes 4, 5, 6; 4 for icodes 8, 9, A, B; else F.
- dstE = rB for icodes 2, 3, 6; 4 for icodes 8, 9, A, B; else F.
- dstM = rA for icodes 5, B; else F.
- src/dst outputs come from the captured values and stay stable from DECODE through PCUPDATE.
- cnd is latched at the end of EXECUTE. For icode 2, wE is suppressed when the latched cnd is 0.
- MEMORY behaviour by icode:
  - Icodes 4, 5, 8, 9, A, B: mem_req is high from MEMORY entry through the mem_ack cycle inclusive.
  - mem_wr is high with mem_req for icodes 4, 8, A.
  - Other icodes: MEMORY lasts one cycle with no request.
- MEMORY exits:
  - mem_ack with dmem_error → stat=ADR, go to HALT; no WRITEBACK.
  - MEM_TIMEOUT cycles without ack → stat=ADR, go to HALT, mem_req drops.
  - mem_ack without dmem_error → go to WRITEBACK.
- WRITEBACK: wE is high if dstE≠F; wM is high if dstM≠F. Both strobes are one cycle. For popq with rA=4, the regfile gives M priority (defined in the regfile).
- PCUPDATE→FETCH.
- HALT is sticky until rst_n is low. start is ignored in HALT.

## Timing
- During reset and after it:
  - State is IDLE; all strobes, wE, wM, mem_req and mem_wr are 0.
  - src/dst are F; stat=AOK; busy=0; halted=0.
- Reset asserted in any state, including mid-MEMORY, takes effect at the next edge. mem_req drops in that same cycle.
- Instruction latency:
  - Non-memory instruction: 6 cycles from FETCH entry to the next FETCH entry.
  - Memory instruction: 5 + N cycles, where N ≥ 1 counts MEMORY cycles. N=1 when ack arrives in the first request cycle.
- FETCH errors halt after 1 cycle; the next cycle has halted=1.
- The timeout counter resets on every MEMORY entry. An ack in the same cycle the count reaches MEM_TIMEOUT wins over the timeout.
- stat updates on the same edge as the HALT transition.
- All outputs are registered or decoded from registered state only; there is no combinational path from input to output.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - Adds cyc_cnt (out, 32) and ret_cnt (out, 32).
  - cyc_cnt increments on every busy cycle.
  - ret_cnt increments on every PCUPDATE cycle.
  - Both clear on reset and saturate at all-ones.
- SEQ_PERF_CNT_EN undefined: both ports and all counter logic are absent.

## Structure
- Package seq_pkg holds:
  - icode constants (HALT…POPQ).
  - stat codes AOK/HLT/ADR/INS.
  - The state enum.
  - REG_NONE=4'hF and REG_RSP=4'h4.
- Sub-module seq_reg_select: combinational derivation of srcA/srcB/dstE/dstM from icode, rA and rB, instantiated once inside the controller.

## Test plan
- Reset, then start, then irmovq (icode 3, rB=2) → strobes F,D,E,M,W,P over 6 cycles; dstE=2, wE for one cycle, dstM=F, mem_req never high.
- mrmovq (icode 5, rA=1, rB=3), ack after 3 request cycles → mem_req high for 3 cycles, mem_wr=0; srcB=3, dstM=1; wM high; 8-cycle instruction.
- cmovxx (icode 2, rA=5, rB=6) with cnd=0, then the same instruction with cnd=1 → srcA=5, dstE=6; wE=0 on the first, wE=1 on the second.
- pushq (icode A, rA=7) with no ack for 15 cycles → mem_req and mem_wr high for 15 cycles, then stat=ADR, halted=1, no WRITEBACK.
- instr_valid=0 at end of FETCH → stat=INS and halted=1 on the next cycle; a later start has no effect until reset.
- popq, with rst_n low during the second MEMORY cycle → next cycle all outputs at reset values and stat=AOK.
